// File: rtl/mem_wb_pipe_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe_stage
//
// Generic pipeline-stage register with a valid/ready handshake, a flush
// (squash) input and a saturating stall-cycle counter. It was written for the
// MEM/WB boundary but works at any stage boundary. The payload is CH channels
// of DATA_W bits, plus CTRL_W control bits and an ADDR_W destination address.
//
// Build option:
//   MEM_WB_PIPE_SKID_EN  defined   : two-entry skid buffer (main + skid).
//                                    ready_o is registered and has no path
//                                    from ready_i.
//                        undefined : single entry. ready_o = !valid_o || ready_i
//                                    is combinational.
//   Both builds have the same ordering, flush and stall-counter behaviour.
//
// Skid-mode controller states:
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_EMPTY | no entry held
//   ST_ONE   | main entry valid, skid slot free
//   ST_FULL  | main and skid entries valid, ready_o = 0
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_n_i      in   asynchronous active-low reset
//   flush_i      in   squash all held entries and the incoming one
//   valid_i      in   upstream entry valid
//   ready_o      out  stage can accept an entry this cycle
//   ctrl_i       in   [CTRL_W-1:0]     control bits
//   data_i       in   [CH*DATA_W-1:0]  payload, channel k at [k*DATA_W +: DATA_W]
//   rdaddr_i     in   [ADDR_W-1:0]     destination register
//   valid_o      out  output entry valid
//   ready_i      in   downstream accepts
//   ctrl_o       out  [CTRL_W-1:0]     control bits, forced to 0 while !valid_o
//   data_o       out  [CH*DATA_W-1:0]  registered payload
//   rdaddr_o     out  [ADDR_W-1:0]     registered destination register
//   stall_cnt_o  out  [15:0]           saturating count of stalled cycles
// -----------------------------------------------------------------------------
module mem_wb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int CH     = 2,
    parameter int CTRL_W = 2,
    parameter int ADDR_W = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [CTRL_W-1:0]    ctrl_i,
    input  logic [CH*DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0]    rdaddr_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [CTRL_W-1:0]    ctrl_o,
    output logic [CH*DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0]    rdaddr_o,
    output logic [15:0]          stall_cnt_o
);

    localparam int PW = CH * DATA_W;

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [PW-1:0]     main_data;
    logic [ADDR_W-1:0] main_addr;

    logic in_xfer;
    logic out_xfer;
    logic in_take;

    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = main_valid && ready_i;
    // A flushed cycle accepts the handshake upstream but drops the entry.
    assign in_take  = in_xfer && !flush_i;

`ifdef MEM_WB_PIPE_SKID_EN

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [PW-1:0]     skid_data;
    logic [ADDR_W-1:0] skid_addr;

    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_take) begin
                        state_nxt    = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_take && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (in_take) begin
                        state_nxt = ST_FULL;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // ready_o is low here, so no input can arrive alongside.
                    if (out_xfer) begin
                        state_nxt      = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    assign main_valid = (state != ST_EMPTY);
    assign skid_valid = (state == ST_FULL);
    assign ready_o    = !skid_valid;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_ctrl <= '0;
            main_data <= '0;
            main_addr <= '0;
        end else if (load_main_in) begin
            main_ctrl <= ctrl_i;
            main_data <= data_i;
            main_addr <= rdaddr_i;
        end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            main_addr <= skid_addr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            skid_ctrl <= '0;
            skid_data <= '0;
            skid_addr <= '0;
        end else if (load_skid) begin
            skid_ctrl <= ctrl_i;
            skid_data <= data_i;
            skid_addr <= rdaddr_i;
        end
    end

`else

    // Single entry: a drain and a load on the same edge replace the entry.
    assign ready_o = !main_valid || ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_valid <= 1'b0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
        end else if (in_take) begin
            main_valid <= 1'b1;
        end else if (out_xfer) begin
            main_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_ctrl <= '0;
            main_data <= '0;
            main_addr <= '0;
        end else if (in_take) begin
            main_ctrl <= ctrl_i;
            main_data <= data_i;
            main_addr <= rdaddr_i;
        end
    end

`endif

    // Stale payload is kept on invalid entries; only ctrl is masked so an
    // empty stage can never trigger a register write downstream.
    assign valid_o  = main_valid;
    assign ctrl_o   = main_valid ? main_ctrl : '0;
    assign data_o   = main_data;
    assign rdaddr_o = main_addr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
        end else if (main_valid && !ready_i && !flush_i && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
module tb_mem_wb_pipe_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        valid_in;
    logic        ready_out;
    logic [1:0]  ctrl_in;
    logic [63:0] data_in;
    logic [4:0]  addr_in;
    logic        valid_out;
    logic        ready_in;
    logic [1:0]  ctrl_out;
    logic [63:0] data_out;
    logic [4:0]  addr_out;
    logic [15:0] stall_cnt;

    // Second instance for the parameter sweep (CH=3, DATA_W=8, ADDR_W=4).
    logic        p_valid_in;
    logic        p_ready_out;
    logic [1:0]  p_ctrl_in;
    logic [23:0] p_data_in;
    logic [3:0]  p_addr_in;
    logic        p_valid_out;
    logic        p_ready_in;
    logic [1:0]  p_ctrl_out;
    logic [23:0] p_data_out;
    logic [3:0]  p_addr_out;
    logic [15:0] p_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int pops    = 0;

    typedef struct {
        logic [1:0]  c;
        logic [63:0] d;
        logic [4:0]  a;
    } ent_t;

    ent_t sb[$];

    mem_wb_pipe_stage dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flush_i     (flush),
        .valid_i     (valid_in),
        .ready_o     (ready_out),
        .ctrl_i      (ctrl_in),
        .data_i      (data_in),
        .rdaddr_i    (addr_in),
        .valid_o     (valid_out),
        .ready_i     (ready_in),
        .ctrl_o      (ctrl_out),
        .data_o      (data_out),
        .rdaddr_o    (addr_out),
        .stall_cnt_o (stall_cnt)
    );

    mem_wb_pipe_stage #(.DATA_W(8), .CH(3), .CTRL_W(2), .ADDR_W(4)) dut_p (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flush_i     (1'b0),
        .valid_i     (p_valid_in),
        .ready_o     (p_ready_out),
        .ctrl_i      (p_ctrl_in),
        .data_i      (p_data_in),
        .rdaddr_i    (p_addr_in),
        .valid_o     (p_valid_out),
        .ready_i     (p_ready_in),
        .ctrl_o      (p_ctrl_out),
        .data_o      (p_data_out),
        .rdaddr_o    (p_addr_out),
        .stall_cnt_o (p_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, then let
    // the rising edge happen. Output transfers are checked against the queue.
    task automatic step(input logic v, input logic [1:0] c, input logic [63:0] d,
                        input logic [4:0] a, input logic rdy, input logic fl,
                        output logic acc);
        ent_t e;
        @(negedge clk);
        valid_in = v;
        ctrl_in  = c;
        data_in  = d;
        addr_in  = a;
        ready_in = rdy;
        flush    = fl;
        #1;
        if (!valid_out) check_eq("ctrl_mask", {62'd0, ctrl_out}, 64'd0);
        if (valid_out && ready_in) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("out_ctrl", {62'd0, ctrl_out}, {62'd0, e.c});
                check_eq("out_data", data_out, e.d);
                check_eq("out_addr", {59'd0, addr_out}, {59'd0, e.a});
                pops++;
            end
        end
        acc = v && ready_out && !fl;
        if (acc) begin
            e.c = c;
            e.d = d;
            e.a = a;
            sb.push_back(e);
        end
        if (fl) sb.delete();
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        step(1'b0, 2'b00, 64'd0, 5'd0, rdy, 1'b0, acc);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            idle(1'b1);
            n++;
        end
        check_eq(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc;
        logic [31:0] ii;
        logic [15:0] st0;
        int          i;
        int          cyc;
        int          pops0;

        rst_n      = 1'b0;
        flush      = 1'b0;
        valid_in   = 1'b0;
        ctrl_in    = 2'b00;
        data_in    = 64'd0;
        addr_in    = 5'd0;
        ready_in   = 1'b0;
        p_valid_in = 1'b0;
        p_ctrl_in  = 2'b00;
        p_data_in  = 24'd0;
        p_addr_in  = 4'd0;
        p_ready_in = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_valid", {63'd0, valid_out}, 64'd0);
        check_eq("rst_ready", {63'd0, ready_out}, 64'd1);
        check_eq("rst_ctrl",  {62'd0, ctrl_out}, 64'd0);
        check_eq("rst_data",  data_out, 64'd0);
        check_eq("rst_addr",  {59'd0, addr_out}, 64'd0);
        check_eq("rst_stall", {48'd0, stall_cnt}, 64'd0);

        // Parameter sweep instance
        @(negedge clk);
        p_valid_in = 1'b1;
        p_ctrl_in  = 2'b10;
        p_data_in  = {8'hA5, 8'h3C, 8'h5A};
        p_addr_in  = 4'h9;
        @(negedge clk);
        p_valid_in = 1'b0;
        #1;
        check_eq("p_valid", {63'd0, p_valid_out}, 64'd1);
        check_eq("p_ch2",   {56'd0, p_data_out[23:16]}, 64'hA5);
        check_eq("p_ch0",   {56'd0, p_data_out[7:0]}, 64'h5A);
        check_eq("p_addr",  {60'd0, p_addr_out}, 64'h9);
        check_eq("p_ctrl",  {62'd0, p_ctrl_out}, 64'h2);

        // Streaming: 8 back-to-back entries, one output per cycle after 1 cycle
        pops0 = pops;
        for (i = 0; i < 8; i++) begin
            ii = 32'(i);
            step(1'b1, 2'b01, {ii, ~ii}, 5'(i), 1'b1, 1'b0, acc);
            check_eq("stream_accept", {63'd0, acc}, 64'd1);
            check_eq("stream_valid", {63'd0, valid_out}, (i == 0) ? 64'd0 : 64'd1);
        end
        idle(1'b1);
        check_eq("stream_pops", 64'(pops - pops0), 64'd8);
        check_eq("stream_empty", 64'(sb.size()), 64'd0);
        idle(1'b1);
        check_eq("stream_idle_valid", {63'd0, valid_out}, 64'd0);

        // Back-pressure: ready_i low for 3 cycles mid-stream
        st0   = stall_cnt;
        pops0 = pops;
        i     = 8;
        cyc   = 0;
        while (i < 16 && cyc < 100) begin
            ii = 32'(i);
            step(1'b1, 2'b01, {ii, ~ii}, 5'(i), !(cyc >= 3 && cyc < 6), 1'b0, acc);
`ifdef MEM_WB_PIPE_SKID_EN
            if (cyc == 3) check_eq("skid_ready_hold", {63'd0, ready_out}, 64'd1);
            if (cyc == 4) check_eq("skid_ready_fall", {63'd0, ready_out}, 64'd0);
`endif
            if (acc) i++;
            cyc++;
        end
        check_eq("bp_budget", {63'd0, (i == 16)}, 64'd1);
        drain("bp_drain");
        check_eq("bp_pops", 64'(pops - pops0), 64'd8);
        check_eq("bp_stall_delta", {48'd0, stall_cnt - st0}, 64'd3);

        // Flush with stage full and an input presented
        step(1'b1, 2'b11, 64'h1111, 5'd20, 1'b0, 1'b0, acc);
        step(1'b1, 2'b11, 64'h2222, 5'd21, 1'b0, 1'b0, acc);
        check_eq("fl_full_valid", {63'd0, valid_out}, 64'd1);
        check_eq("fl_full_ready", {63'd0, ready_out}, 64'd0);
        step(1'b1, 2'b11, 64'h3333, 5'd22, 1'b0, 1'b1, acc);
        st0 = stall_cnt;
        idle(1'b0);
        check_eq("fl_valid", {63'd0, valid_out}, 64'd0);
        check_eq("fl_ctrl",  {62'd0, ctrl_out}, 64'd0);
        check_eq("fl_stall", {48'd0, stall_cnt}, {48'd0, st0});
        idle(1'b1);
        idle(1'b1);
        check_eq("fl_discard", {63'd0, valid_out}, 64'd0);

        // Reset mid-stream, between clock edges
        step(1'b1, 2'b01, 64'hDEAD, 5'd3, 1'b0, 1'b0, acc);
        idle(1'b0);
        check_eq("mrst_pre_valid", {63'd0, valid_out}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_valid", {63'd0, valid_out}, 64'd0);
        check_eq("mrst_ctrl",  {62'd0, ctrl_out}, 64'd0);
        check_eq("mrst_ready", {63'd0, ready_out}, 64'd1);
        check_eq("mrst_stall", {48'd0, stall_cnt}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the stall counter
        step(1'b1, 2'b10, 64'hCAFE, 5'd7, 1'b0, 1'b0, acc);
        repeat (70000) idle(1'b0);
        check_eq("sat_value", {48'd0, stall_cnt}, 64'hFFFF);
        repeat (3) idle(1'b0);
        check_eq("sat_hold", {48'd0, stall_cnt}, 64'hFFFF);
        check_eq("sat_valid", {63'd0, valid_out}, 64'd1);
        pops0 = pops;
        drain("sat_drain");
        check_eq("sat_pops", 64'(pops - pops0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
